// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pipe
// Description : Registered, handshaked RV32I decode stage. Decodes the base
//               integer formats, resolves operands with EX/WB forwarding,
//               stalls on load-use hazards and counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter bit EN_FWD = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  inst_addr_i,
    input  logic             flush_i,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             ex_wen_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [XLEN-1:0]  ex_data_i,
    input  logic             ex_load_i,
    input  logic             wb_wen_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  inst_addr_o,
    output logic [XLEN-1:0]  op1_o,
    output logic [XLEN-1:0]  op2_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [4:0]       rd_addr_o,
    output logic             reg_wen_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1_field;
    logic [4:0]      w_rs2_field;
    logic [4:0]      w_rd_field;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    logic            w_use_rs1, w_use_rs2, w_writes, w_illegal;
    logic [XLEN-1:0] w_op1, w_op2, w_imm;
    logic [4:0]      w_rd;
    logic            w_wen;
    logic            w_hazard;
    logic            w_capture;

    logic             r_valid;
    logic [31:0]      r_inst;
    logic [XLEN-1:0]  r_addr, r_op1, r_op2, r_imm;
    logic [4:0]       r_rd;
    logic             r_wen, r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_opcode    = inst_i[6:0];
    assign w_funct3    = inst_i[14:12];
    assign w_rs1_field = inst_i[19:15];
    assign w_rs2_field = inst_i[24:20];
    assign w_rd_field  = inst_i[11:7];

    assign w_imm_i = XLEN'($signed(inst_i[31:20]));
    assign w_imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign w_imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({inst_i[31:12], 12'h000}));
    assign w_imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign w_shamt = XLEN'(inst_i[24:20]);

    // Operand resolution uses the raw register fields; the decoder only routes
    // a resolved value when that register is actually read by the format.
    // EX wins over WB, and a load still in EX cannot forward its data yet.
    assign w_rs1_val = (w_rs1_field == 5'd0) ? '0 :
                       (EN_FWD && ex_wen_i && !ex_load_i && ex_rd_i == w_rs1_field) ? ex_data_i :
                       (EN_FWD && wb_wen_i && wb_rd_i == w_rs1_field) ? wb_data_i : rs1_data_i;
    assign w_rs2_val = (w_rs2_field == 5'd0) ? '0 :
                       (EN_FWD && ex_wen_i && !ex_load_i && ex_rd_i == w_rs2_field) ? ex_data_i :
                       (EN_FWD && wb_wen_i && wb_rd_i == w_rs2_field) ? wb_data_i : rs2_data_i;

    // Decode the incoming instruction into register usage, operands and immediate.
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        w_illegal = 1'b0;
        w_op1     = '0;
        w_op2     = '0;
        w_imm     = '0;
        case (w_opcode)
            c_OP_IMM: begin
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
                w_imm     = w_imm_i;
                w_op1     = w_rs1_val;
                w_op2     = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? w_shamt : w_imm_i;
            end
            c_OP_REG: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_writes  = 1'b1;
                w_op1     = w_rs1_val;
                w_op2     = w_rs2_val;
            end
            c_OP_BRANCH: begin
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
                    w_illegal = 1'b1;
                end else begin
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                    w_imm     = w_imm_b;
                    w_op1     = w_rs1_val;
                    w_op2     = w_rs2_val;
                end
            end
            c_OP_LOAD: begin
                if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
                    w_illegal = 1'b1;
                end else begin
                    w_use_rs1 = 1'b1;
                    w_writes  = 1'b1;
                    w_imm     = w_imm_i;
                    w_op1     = w_rs1_val;
                    w_op2     = w_imm_i;
                end
            end
            c_OP_STORE: begin
                if (w_funct3[2] || w_funct3 == 3'b011) begin
                    w_illegal = 1'b1;
                end else begin
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                    w_imm     = w_imm_s;
                    w_op1     = w_rs1_val;
                    w_op2     = w_rs2_val;
                end
            end
            c_OP_JAL: begin
                w_writes = 1'b1;
                w_imm    = w_imm_j;
                w_op1    = w_imm_j;
            end
            c_OP_JALR: begin
                if (w_funct3 != 3'b000) begin
                    w_illegal = 1'b1;
                end else begin
                    w_use_rs1 = 1'b1;
                    w_writes  = 1'b1;
                    w_imm     = w_imm_i;
                    w_op1     = w_rs1_val;
                    w_op2     = w_imm_i;
                end
            end
            c_OP_LUI: begin
                w_writes = 1'b1;
                w_imm    = w_imm_u;
                w_op1    = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_writes = 1'b1;
                w_imm    = w_imm_u;
                w_op1    = w_imm_u;
                w_op2    = inst_addr_i;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign rs1_addr_o = w_use_rs1 ? w_rs1_field : 5'd0;
    assign rs2_addr_o = w_use_rs2 ? w_rs2_field : 5'd0;

    // Writes to x0 are dropped entirely, so rd is reported as 0 as well.
    assign w_wen = w_writes && (w_rd_field != 5'd0);
    assign w_rd  = w_wen ? w_rd_field : 5'd0;

    // Unused read addresses are 0 and ex_rd must be non-zero, so comparing
    // against both address outputs only matches registers really read.
    assign w_hazard = in_valid_i && ex_load_i && ex_wen_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == rs1_addr_o) || (ex_rd_i == rs2_addr_o));

    assign in_ready_o = (!r_valid || out_ready_i) && !w_hazard;
    assign w_capture  = in_valid_i && in_ready_o;

    // Output bundle register: flush beats capture, capture beats drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_inst    <= '0;
            r_addr    <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_wen     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_inst    <= inst_i;
            r_addr    <= inst_addr_i;
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_imm     <= w_imm;
            r_rd      <= w_rd;
            r_wen     <= w_wen;
            r_illegal <= w_illegal;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating count of load-use stall cycles; unaffected by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid_o = r_valid;
    assign inst_o      = r_inst;
    assign inst_addr_o = r_addr;
    assign op1_o       = r_op1;
    assign op2_o       = r_op2;
    assign imm_o       = r_imm;
    assign rd_addr_o   = r_rd;
    assign reg_wen_o   = r_wen;
    assign illegal_o   = r_illegal;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire
